// File: rtl/param_serializer.sv
// Parametrised parallel-to-serial converter with ready handshake and length field.
// Optional zero-bubble back-to-back operation when SER_PRELOAD_EN is defined.
module param_serializer #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned LEN_W     = $clog2(DATA_W),
  parameter int unsigned MIN_LEN   = 3,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [LEN_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              ready_o,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              busy_o
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                ser_data_q, ser_data_d;
  logic                ser_val_q, ser_val_d;
  logic                busy_q, busy_d;

  logic [LEN_W:0]      len_c;
  logic                len_ok_c;
  logic                last_c;
  logic                load_c;
  logic                first_bit_c;
  logic [DATA_W-1:0]   rest_c;
  logic                next_bit_c;
  logic [DATA_W-1:0]   shifted_c;

  // Effective length: a zero length field selects the full word.
  always_comb begin
    len_c    = (data_mod_i == '0) ? (LEN_W+1)'(DATA_W) : {1'b0, data_mod_i};
    len_ok_c = (len_c >= (LEN_W+1)'(MIN_LEN));
  end

  assign last_c = (state_q == ST_SHIFT) && (cnt_q == '0);

`ifdef SER_PRELOAD_EN
  assign ready_o = (state_q == ST_IDLE) || last_c;
`else
  assign ready_o = (state_q == ST_IDLE);
`endif

  assign load_c = data_val_i && ready_o && len_ok_c;

  // Bit-order selection for the first bit of a new word and for the running shift.
  always_comb begin
    if (MSB_FIRST) begin
      first_bit_c = data_i[DATA_W-1];
      rest_c      = data_i << 1;
      next_bit_c  = shreg_q[DATA_W-1];
      shifted_c   = shreg_q << 1;
    end else begin
      first_bit_c = data_i[0];
      rest_c      = data_i >> 1;
      next_bit_c  = shreg_q[0];
      shifted_c   = shreg_q >> 1;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    ser_data_d = 1'b0;
    ser_val_d  = 1'b0;
    busy_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_c) begin
          state_d    = ST_SHIFT;
          shreg_d    = rest_c;
          cnt_d      = LEN_W'(len_c - (LEN_W+1)'(1));
          ser_data_d = first_bit_c;
          ser_val_d  = 1'b1;
          busy_d     = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (load_c) begin
          // Preload on the last-bit cycle keeps the stream contiguous.
          shreg_d    = rest_c;
          cnt_d      = LEN_W'(len_c - (LEN_W+1)'(1));
          ser_data_d = first_bit_c;
          ser_val_d  = 1'b1;
          busy_d     = 1'b1;
        end else if (last_c) begin
          state_d = ST_IDLE;
        end else begin
          shreg_d    = shifted_c;
          cnt_d      = cnt_q - LEN_W'(1);
          ser_data_d = next_bit_c;
          ser_val_d  = 1'b1;
          busy_d     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      ser_data_q <= 1'b0;
      ser_val_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      ser_data_q <= ser_data_d;
      ser_val_q  <= ser_val_d;
      busy_q     <= busy_d;
    end
  end

  assign ser_data_o     = ser_data_q;
  assign ser_data_val_o = ser_val_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_param_serializer.sv
// Bench for param_serializer: MSB-first and LSB-first instances driven in parallel,
// checked every cycle against a queue-of-bits reference model.
module tb_param_serializer;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned MIN_LEN = 3;

  logic              clk = 1'b0;
  logic              srst;
  logic [DATA_W-1:0] data;
  logic [LEN_W-1:0]  mod;
  logic              val;

  logic rdy_m, dat_m, dval_m, busy_m;
  logic rdy_l, dat_l, dval_l, busy_l;
  logic [7:0] obs;

  int errors = 0;
  int checks = 0;

  // Expected serial bit stream still to be emitted, one queue per bit order.
  bit qm[$];
  bit ql[$];

  always #5 clk = ~clk;

  param_serializer #(.DATA_W(DATA_W), .MIN_LEN(MIN_LEN), .MSB_FIRST(1'b1)) dut_m (
    .clk_i(clk), .srst_i(srst), .data_i(data), .data_mod_i(mod), .data_val_i(val),
    .ready_o(rdy_m), .ser_data_o(dat_m), .ser_data_val_o(dval_m), .busy_o(busy_m)
  );

  param_serializer #(.DATA_W(DATA_W), .MIN_LEN(MIN_LEN), .MSB_FIRST(1'b0)) dut_l (
    .clk_i(clk), .srst_i(srst), .data_i(data), .data_mod_i(mod), .data_val_i(val),
    .ready_o(rdy_l), .ser_data_o(dat_l), .ser_data_val_o(dval_l), .busy_o(busy_l)
  );

  assign obs = {rdy_m, busy_m, dval_m, dat_m, rdy_l, busy_l, dval_l, dat_l};

  function automatic bit m_ready();
`ifdef SER_PRELOAD_EN
    return qm.size() <= 1;
`else
    return qm.size() == 0;
`endif
  endfunction

  function automatic logic [3:0] exp_vec(input bit lsb);
    if (qm.size() == 0) return 4'b1000;
    return {m_ready(), 2'b11, lsb ? ql[0] : qm[0]};
  endfunction

  // Advance model and clock by one edge using the currently driven inputs.
  task automatic step();
    int len;
    bit acc;
    len = (mod == 0) ? int'(DATA_W) : int'(mod);
    acc = val && m_ready() && (len >= int'(MIN_LEN));
    if (qm.size() != 0) begin
      void'(qm.pop_front());
      void'(ql.pop_front());
    end
    if (srst) begin
      qm.delete();
      ql.delete();
    end else if (acc) begin
      for (int i = 0; i < len; i++) begin
        qm.push_back(data[DATA_W-1-i]);
        ql.push_back(data[i]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    srst = 1'b1; val = 1'b0; data = '0; mod = '0;
    step();
    step();
    srst = 1'b0;
    checks++;
    if (obs !== 8'b1000_1000) begin
      errors++;
      $display("FAIL reset_state got=%b want=%b", obs, 8'b1000_1000);
    end
  endtask

  task automatic test_full_word();
    logic [15:0] col;
    int n;
    col = '0; n = 0;
    data = 16'hA5C3; mod = '0; val = 1'b1;
    step();
    for (int c = 0; c < 18; c++) begin
      checks++;
      if (obs !== {exp_vec(1'b0), exp_vec(1'b1)}) begin
        errors++;
        $display("FAIL full_word cyc=%0d got=%b want=%b", c, obs, {exp_vec(1'b0), exp_vec(1'b1)});
      end
      if (dval_m) begin
        col = {col[14:0], dat_m};
        n++;
      end
      val  = (c == 4);
      data = (c == 4) ? 16'hFFFF : 16'($urandom);
      mod  = LEN_W'($urandom);
      step();
    end
    checks++;
    if (col !== 16'hA5C3 || n != 16) begin
      errors++;
      $display("FAIL full_word_stream got=%h/%0d want=a5c3/16", col, n);
    end
  endtask

  task automatic test_short_len();
    logic [15:0] words [2];
    int ones_m, ones_l, n;
    words[0] = 16'hF800;
    words[1] = 16'h001F;
    for (int w = 0; w < 2; w++) begin
      ones_m = 0; ones_l = 0; n = 0;
      data = words[w]; mod = 4'd5; val = 1'b1;
      step();
      val = 1'b0;
      for (int c = 0; c < 7; c++) begin
        checks++;
        if (obs !== {exp_vec(1'b0), exp_vec(1'b1)}) begin
          errors++;
          $display("FAIL short_len w=%0d cyc=%0d got=%b want=%b", w, c, obs, {exp_vec(1'b0), exp_vec(1'b1)});
        end
        if (dval_m) begin n++; ones_m += int'(dat_m); end
        if (dval_l) ones_l += int'(dat_l);
        step();
      end
      checks++;
      if (n != 5 || ones_m != (w == 0 ? 5 : 0) || ones_l != (w == 0 ? 0 : 5)) begin
        errors++;
        $display("FAIL short_len_count w=%0d got n=%0d m=%0d l=%0d", w, n, ones_m, ones_l);
      end
    end
  endtask

  task automatic test_drop();
    for (int m = 1; m <= 2; m++) begin
      data = 16'($urandom); mod = LEN_W'(m); val = 1'b1;
      step();
      val = 1'b0;
      for (int c = 0; c < 2; c++) begin
        checks++;
        if (obs !== 8'b1000_1000 || obs !== {exp_vec(1'b0), exp_vec(1'b1)}) begin
          errors++;
          $display("FAIL drop len=%0d cyc=%0d got=%b want=%b", m, c, obs, 8'b1000_1000);
        end
        step();
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] col;
    int n;
    data = 16'($urandom); mod = '0; val = 1'b1;
    step();
    val = 1'b0;
    for (int c = 0; c < 7; c++) step();
    srst = 1'b1;
    step();
    srst = 1'b0;
    checks++;
    if (obs !== 8'b1000_1000 || obs !== {exp_vec(1'b0), exp_vec(1'b1)}) begin
      errors++;
      $display("FAIL reset_mid got=%b want=%b", obs, 8'b1000_1000);
    end
    col = '0; n = 0;
    data = 16'h3C96; mod = '0; val = 1'b1;
    step();
    val = 1'b0;
    for (int c = 0; c < 17; c++) begin
      checks++;
      if (obs !== {exp_vec(1'b0), exp_vec(1'b1)}) begin
        errors++;
        $display("FAIL after_reset cyc=%0d got=%b want=%b", c, obs, {exp_vec(1'b0), exp_vec(1'b1)});
      end
      if (dval_m) begin col = {col[14:0], dat_m}; n++; end
      step();
    end
    checks++;
    if (col !== 16'h3C96 || n != 16) begin
      errors++;
      $display("FAIL after_reset_stream got=%h/%0d want=3c96/16", col, n);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [2];
    logic [16:0] vp, dp, vp_exp, dp_exp;
    int k;
    words[0] = {8'hAA, 8'h55};
    words[1] = {8'h55, 8'hAA};
    k = 0; vp = '0; dp = '0;
`ifdef SER_PRELOAD_EN
    vp_exp = 17'b11111111111111110;
    dp_exp = 17'b10101010010101010;
`else
    vp_exp = 17'b11111111011111111;
    dp_exp = 17'b10101010001010101;
`endif
    for (int c = 0; c < 20; c++) begin
      val  = (k < 2);
      data = (k == 0) ? words[0] : words[1];
      mod  = 4'd8;
      if (val && m_ready()) k++;
      step();
      checks++;
      if (obs !== {exp_vec(1'b0), exp_vec(1'b1)}) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d got=%b want=%b", c, obs, {exp_vec(1'b0), exp_vec(1'b1)});
      end
      if (c < 17) begin
        vp = {vp[15:0], dval_m};
        dp = {dp[15:0], dat_m};
      end
    end
    val = 1'b0;
    checks++;
    if (vp !== vp_exp || dp !== dp_exp) begin
      errors++;
      $display("FAIL back_to_back_pattern got val=%b dat=%b want val=%b dat=%b", vp, dp, vp_exp, dp_exp);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      srst = ($urandom_range(0, 59) == 0);
      val  = ($urandom_range(0, 2) != 0);
      data = 16'($urandom);
      mod  = ($urandom_range(0, 3) == 0) ? LEN_W'($urandom_range(0, 3)) : LEN_W'($urandom);
      step();
      checks++;
      if (obs !== {exp_vec(1'b0), exp_vec(1'b1)}) begin
        errors++;
        $display("FAIL random cyc=%0d got=%b want=%b", c, obs, {exp_vec(1'b0), exp_vec(1'b1)});
      end
    end
    srst = 1'b0;
    val  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_short_len();
    test_drop();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_serializer.md
Name: param_serializer

Overview:
Parametrised, next-generation serializer: takes a DATA_W-bit parallel word and a length field, then shifts out the selected bits one per clock with a valid strobe.
- Adds configurable width, bit order and minimum legal length.
- Adds an explicit ready handshake and optional zero-bubble back-to-back operation.
- Sits between word-oriented producers and single-wire serial links in the datapath.

Parameters:
DATA_W, 16, parallel word width (>=4)
LEN_W, $clog2(DATA_W), width of data_mod_i (derived, do not override)
MIN_LEN, 3, shortest legal word length in bits; shorter requests are dropped
MSB_FIRST, 1, 1 = shift out from bit DATA_W-1 downward; 0 = from bit 0 upward

Ports:
clk_i  input  1  single clock, all logic on rising edge
srst_i  input  1  synchronous active-high reset
data_i  input  DATA_W  parallel word
data_mod_i  input  LEN_W  number of bits to send; 0 means DATA_W
data_val_i  input  1  data_i/data_mod_i valid this cycle
ready_o  output  1  block can accept a word this cycle
ser_data_o  output  1  serial bit
ser_data_val_o  output  1  ser_data_o valid
busy_o  output  1  serialization in progress

Behaviour:
- Reset: ser_data_o=0, ser_data_val_o=0, busy_o=0, ready_o=1, shift register and bit counter cleared.
- srst_i wins over everything, including mid-word: the word is discarded and outputs go to reset values on the next edge.
- Accept condition: data_val_i && ready_o. Without the macro, ready_o = !busy_o.
- Effective length: len = (data_mod_i==0) ? DATA_W : data_mod_i.
- If len < MIN_LEN, the word is silently dropped. No busy, no valid pulse, ready_o stays 1.
- FSM states:
  - IDLE: ready_o=1, outputs low. Legal accept -> SHIFT; word and len latched.
  - SHIFT: busy_o=1, ser_data_val_o=1, one bit per cycle.
- Latency: first bit appears on ser_data_o in the cycle after accept. Exactly len consecutive valid cycles follow, with no gaps.
- Bit order:
  - MSB_FIRST=1: data_i[DATA_W-1], data_i[DATA_W-2] ... data_i[DATA_W-len].
  - MSB_FIRST=0: data_i[0] ... data_i[len-1].
- Bit counter counts down from len-1. On the cycle it reaches 0 (last bit), the state returns to IDLE at the next edge, unless a preload occurs (see Optional Feature).
- Outside SHIFT, ser_data_o is forced to 0.
- data_val_i while ready_o=0: ignored. No buffering; the producer must hold or retry.
- data_i and data_mod_i changes during SHIFT have no effect; only the latched copy is used.
- Without the macro, back-to-back words have a one-cycle bubble: busy_o=0 for one cycle between them.
- All outputs are registered except ready_o, which is combinational from state only (never from data_val_i).

Optional Feature:
Macro SER_PRELOAD_EN.
- Defined: ready_o = !busy_o || (busy_o && last-bit cycle). A word accepted on the last-bit cycle starts shifting on the very next cycle. Both busy_o and ser_data_val_o stay continuously high, so back-to-back streams have zero bubbles.
- Defined, dropped preload: a dropped (len<MIN_LEN) word offered on the last-bit cycle returns the block to IDLE normally.
- Not defined: ready_o = !busy_o, and the one-cycle bubble applies.

Test Plan:
1. Reset, then data_i=16'hA5C3, data_mod_i=0, val for 1 cycle (MSB_FIRST=1) -> next 16 cycles ser_data_val_o=1, ser_data_o = 1010010111000011, busy_o=1 throughout, then both 0.
2. data_i=16'hF800, data_mod_i=5 -> exactly 5 valid cycles of bit 1, then idle. Repeat with MSB_FIRST=0 and data_i=16'h001F -> same 5 ones.
3. data_mod_i=2 and data_mod_i=1 with val -> no ser_data_val_o, busy_o stays 0, ready_o stays 1.
4. During the word from test 1, pulse data_val_i with 16'hFFFF at bit 4 -> ignored; the output sequence is unchanged.
5. Assert srst_i at bit 7 of a 16-bit word -> next cycle all outputs 0 and ready_o=1. A new word accepted afterwards serializes correctly from its first bit.
6. Two 8-bit words 8'hAA,8'h55 (data_mod_i=8) offered whenever ready_o=1:
   - Without SER_PRELOAD_EN: one-cycle valid gap between words.
   - With SER_PRELOAD_EN: 16 contiguous valid bits 1010101001010101.
